// File: rtl/servo_pwm_bridge.sv
// Servo command to H-bridge gate driver: free-running PWM period, boundary-synchronous
// duty/direction updates, reversal guard period, minimum pulse, saturation, sticky fault.
module servo_pwm_bridge #(
    parameter int unsigned PERIOD     = 2000,
    parameter int unsigned DEAD_TIME  = 20,
    parameter int unsigned DUTY_SHIFT = 4,
    parameter int unsigned MIN_PULSE  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] u,
    input  logic        u_valid,
    input  logic        fault,
    input  logic        fault_clr,
    output logic        hi_a,
    output logic        lo_a,
    output logic        hi_b,
    output logic        lo_b,
    output logic        period_st,
    output logic        dir_o,
    output logic [15:0] duty_o,
    output logic        sat,
    output logic        fault_flag
);

    localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] DUTY_MAX = 16'(PERIOD - 2 * DEAD_TIME);
    localparam logic [15:0] MIN_P    = 16'(MIN_PULSE);
    localparam logic [16:0] DT17     = 17'(DEAD_TIME);
    localparam logic [16:0] LO_END   = 17'(PERIOD - DEAD_TIME);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWAP  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Returns {sat, duty}; the most negative command is folded onto +0x7FFF.
    function automatic logic [16:0] duty_calc(input logic [15:0] cmd);
        logic [15:0] mag;
        logic [15:0] d;
        logic        s;
        if (cmd == 16'h8000) begin
            mag = 16'h7FFF;
        end else if (cmd[15]) begin
            mag = ~cmd + 16'd1;
        end else begin
            mag = cmd;
        end
        d = mag >> DUTY_SHIFT;
        if (d < MIN_P) begin
            d = 16'd0;
        end else begin
            d = d;
        end
        if (d > DUTY_MAX) begin
            d = DUTY_MAX;
            s = 1'b1;
        end else begin
            s = 1'b0;
        end
        return {s, d};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        sat_q, sat_d;
    logic        fault_flag_q, fault_flag_d;
    logic        period_st_q, period_st_d;
    logic        hi_a_q, hi_a_d, lo_a_q, lo_a_d, hi_b_q, hi_b_d, lo_b_q, lo_b_d;

    logic        bnd_s;
    logic [15:0] cmd_s;
    logic [15:0] cmd_duty_s;
    logic        cmd_sat_s;
    logic        cmd_dir_s;
    logic        rev_s;
    logic        load_s;
    logic        hi_win_s;
    logic        lo_win_s;

    // Boundary command evaluation: a strobe in the boundary cycle wins over pending.
    always_comb begin
        bnd_s                   = (cnt_q == CNT_LAST);
        cmd_s                   = u_valid ? u : pending_q;
        {cmd_sat_s, cmd_duty_s} = duty_calc(cmd_s);
        cmd_dir_s               = (cmd_duty_s != 16'd0) ? cmd_s[15] : dir_q;
        rev_s                   = (cmd_dir_s != dir_q);
        load_s                  = bnd_s && !fault && enable && (state_q != ST_FAULT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fault and enable-low override the per-state behaviour.
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (enable && bnd_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_RUN, ST_SWAP: begin
                    if (!enable) begin
                        state_d = ST_OFF;
                    end else if (bnd_s) begin
                        state_d = rev_s ? ST_SWAP : ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_OFF;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Counter, command latch and applied-command registers.
    always_comb begin
        cnt_d        = (cnt_q == CNT_LAST) ? 16'd0 : cnt_q + 16'd1;
        pending_d    = u_valid ? u : pending_q;
        duty_d       = load_s ? cmd_duty_s : duty_q;
        dir_d        = load_s ? cmd_dir_s : dir_q;
        sat_d        = load_s ? cmd_sat_s : sat_q;
        period_st_d  = (cnt_d == CNT_LAST);
        fault_flag_d = (state_d == ST_FAULT);
    end

    // Output decode: gate windows come from this cycle's counter, state and duty.
    always_comb begin
        hi_win_s = (cnt_q < duty_q);
        lo_win_s = ({1'b0, cnt_q} >= ({1'b0, duty_q} + DT17)) && ({1'b0, cnt_q} < LO_END);
        hi_a_d   = 1'b0;
        lo_a_d   = 1'b0;
        hi_b_d   = 1'b0;
        lo_b_d   = 1'b0;
        if (fault || !enable || (state_q != ST_RUN)) begin
            hi_a_d = 1'b0;
        end else if (!dir_q) begin
            hi_a_d = hi_win_s;
            lo_a_d = lo_win_s && !hi_win_s;
            lo_b_d = 1'b1;
        end else begin
            hi_b_d = hi_win_s;
            lo_b_d = lo_win_s && !hi_win_s;
            lo_a_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 16'd0;
            pending_q    <= 16'd0;
            duty_q       <= 16'd0;
            dir_q        <= 1'b0;
            sat_q        <= 1'b0;
            period_st_q  <= 1'b0;
            fault_flag_q <= 1'b0;
            hi_a_q       <= 1'b0;
            lo_a_q       <= 1'b0;
            hi_b_q       <= 1'b0;
            lo_b_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            duty_q       <= duty_d;
            dir_q        <= dir_d;
            sat_q        <= sat_d;
            period_st_q  <= period_st_d;
            fault_flag_q <= fault_flag_d;
            hi_a_q       <= hi_a_d;
            lo_a_q       <= lo_a_d;
            hi_b_q       <= hi_b_d;
            lo_b_q       <= lo_b_d;
        end
    end

    assign hi_a       = hi_a_q;
    assign lo_a       = lo_a_q;
    assign hi_b       = hi_b_q;
    assign lo_b       = lo_b_q;
    assign period_st  = period_st_q;
    assign dir_o      = dir_q;
    assign duty_o     = duty_q;
    assign sat        = sat_q;
    assign fault_flag = fault_flag_q;

endmodule

// File: tb/tb_servo_pwm_bridge.sv
// Self-checking bench for servo_pwm_bridge: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the bridge.
module tb_servo_pwm_bridge;

    localparam int P    = 2000;
    localparam int DT   = 20;
    localparam int SH   = 4;
    localparam int MINP = 8;

    localparam int S_OFF  = 0;
    localparam int S_RUN  = 1;
    localparam int S_SWAP = 2;
    localparam int S_FLT  = 3;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] u;
    logic        u_valid;
    logic        fault;
    logic        fault_clr;
    logic        hi_a, lo_a, hi_b, lo_b;
    logic        period_st;
    logic        dir_o;
    logic [15:0] duty_o;
    logic        sat;
    logic        fault_flag;

    servo_pwm_bridge #(
        .PERIOD(P), .DEAD_TIME(DT), .DUTY_SHIFT(SH), .MIN_PULSE(MINP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .u(u), .u_valid(u_valid),
        .fault(fault), .fault_clr(fault_clr),
        .hi_a(hi_a), .lo_a(lo_a), .hi_b(hi_b), .lo_b(lo_b),
        .period_st(period_st), .dir_o(dir_o), .duty_o(duty_o), .sat(sat),
        .fault_flag(fault_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int n_print = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
            end
        end
    endtask

    // Model of the bridge as the rules describe it.
    int          m_cnt = 0;
    int          m_st = S_OFF;
    int          m_duty = 0;
    int          m_sat = 0;
    int          m_dir = 0;
    logic [15:0] m_pend = 16'd0;
    bit          m_ok = 1'b0;
    int          e_ha, e_la, e_hb, e_lb;

    function automatic int calc_duty(input logic [15:0] cmd, output int s);
        int v, mag, d;
        v   = $signed(cmd);
        mag = (v < 0) ? -v : v;
        if (mag > 32767) mag = 32767;
        d = mag / (1 << SH);
        if (d < MINP) d = 0;
        s = (d > P - 2 * DT) ? 1 : 0;
        if (s == 1) d = P - 2 * DT;
        return d;
    endfunction

    initial begin
        int          d, s, nd, on_hi, on_lo;
        logic [15:0] cmd;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_cnt = 0; m_st = S_OFF; m_pend = 16'd0;
                m_duty = 0; m_dir = 0; m_sat = 0;
                e_ha = 0; e_la = 0; e_hb = 0; e_lb = 0;
                m_ok = 1'b1;
            end else if (m_ok) begin
                e_ha = 0; e_la = 0; e_hb = 0; e_lb = 0;
                if (!fault && enable && m_st == S_RUN) begin
                    on_hi = (m_cnt < m_duty) ? 1 : 0;
                    on_lo = (m_cnt >= m_duty + DT && m_cnt < P - DT) ? 1 : 0;
                    if (m_dir == 0) begin
                        e_ha = on_hi; e_la = on_lo; e_lb = 1;
                    end else begin
                        e_hb = on_hi; e_lb = on_lo; e_la = 1;
                    end
                end
                cmd = u_valid ? u : m_pend;
                d   = calc_duty(cmd, s);
                nd  = (d != 0) ? int'(cmd[15]) : m_dir;
                if (fault) begin
                    m_st = S_FLT;
                end else if (m_st == S_FLT) begin
                    if (fault_clr) m_st = S_OFF;
                end else if (m_st != S_OFF && !enable) begin
                    m_st = S_OFF;
                end else if (m_cnt == P - 1 && enable) begin
                    if (m_st == S_OFF) m_st = S_RUN;
                    else m_st = (nd != m_dir) ? S_SWAP : S_RUN;
                    m_duty = d; m_sat = s; m_dir = nd;
                end
                m_cnt = (m_cnt + 1) % P;
                if (u_valid) m_pend = u;
            end
            #1;
            if (m_ok) begin
                chk("hi_a", int'(hi_a), e_ha);
                chk("lo_a", int'(lo_a), e_la);
                chk("hi_b", int'(hi_b), e_hb);
                chk("lo_b", int'(lo_b), e_lb);
                chk("period_st", int'(period_st), (m_cnt == P - 1) ? 1 : 0);
                chk("dir_o", int'(dir_o), m_dir);
                chk("duty_o", int'(duty_o), m_duty);
                chk("sat", int'(sat), m_sat);
                chk("fault_flag", int'(fault_flag), (m_st == S_FLT) ? 1 : 0);
                chk("shoot_a", int'(hi_a & lo_a), 0);
                chk("shoot_b", int'(hi_b & lo_b), 0);
            end
        end
    end

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        u = v; u_valid = 1'b1;
        @(negedge clk);
        u_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while (m_cnt != k && n < P + 2) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != k) chk("wait_cnt_timeout", m_cnt, k);
    endtask

    task automatic wait_periods(input int n);
        repeat (n * P) @(negedge clk);
    endtask

    task automatic count_period(output int cha, output int cla, output int chb, output int clb);
        cha = 0; cla = 0; chb = 0; clb = 0;
        wait_cnt(0);
        for (int i = 0; i < P; i++) begin
            cha += int'(hi_a); cla += int'(lo_a);
            chb += int'(hi_b); clb += int'(lo_b);
            @(negedge clk);
        end
    endtask

    initial begin
        int ha, la, hb, lb;
        logic [15:0] rv;
        rst = 1'b1; enable = 1'b0; u = 16'd0; u_valid = 1'b0;
        fault = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", int'(duty_o), 0);
        chk("rst_gates", int'({hi_a, lo_a, hi_b, lo_b}), 0);
        chk("rst_flags", int'({period_st, dir_o, sat, fault_flag}), 0);
        rst = 1'b0;

        // Arm with +0x0800: duty 128, hi_a 128 cycles, lo_a 148..1979.
        enable = 1'b1;
        strobe(16'h0800);
        wait_periods(1);
        count_period(ha, la, hb, lb);
        chk("arm_duty", int'(duty_o), 128);
        chk("arm_dir", int'(dir_o), 0);
        chk("arm_hi_a_cnt", ha, 128);
        chk("arm_lo_a_cnt", la, 1832);
        chk("arm_lo_b_cnt", lb, 2000);
        chk("arm_hi_b_cnt", hb, 0);

        // Saturation both signs.
        strobe(16'h7FFF);
        wait_periods(2);
        chk("sat_pos_duty", int'(duty_o), 1960);
        chk("sat_pos_flag", int'(sat), 1);
        strobe(16'h8000);
        wait_periods(2);
        chk("sat_neg_duty", int'(duty_o), 1960);
        chk("sat_neg_dir", int'(dir_o), 1);
        chk("sat_neg_flag", int'(sat), 1);

        // Minimum pulse: d = 7 -> 0, only the low switch with dead time.
        strobe(16'h0800);
        wait_periods(2);
        strobe(16'h0070);
        wait_periods(1);
        count_period(ha, la, hb, lb);
        chk("minp_duty", int'(duty_o), 0);
        chk("minp_hi_a_cnt", ha, 0);
        chk("minp_lo_a_cnt", la, 1960);

        // Small negative command after positive: no reversal, no guard period.
        strobe(16'hFFF0);
        wait_periods(1);
        count_period(ha, la, hb, lb);
        chk("zero_dir", int'(dir_o), 0);
        chk("zero_lo_a_cnt", la, 1960);
        chk("zero_lo_b_cnt", lb, 2000);

        // Reversal +0x0800 -> -0x0800.
        strobe(16'h0800);
        wait_periods(2);
        strobe(16'hF800);
        wait_periods(2);
        count_period(ha, la, hb, lb);
        chk("rev_dir", int'(dir_o), 1);
        chk("rev_hi_b_cnt", hb, 128);
        chk("rev_lo_a_cnt", la, 2000);
        chk("rev_hi_a_cnt", ha, 0);

        // Strobe exactly in the boundary cycle.
        wait_cnt(P - 1);
        u = 16'h1000; u_valid = 1'b1;
        @(negedge clk);
        u_valid = 1'b0;
        chk("bnd_duty", int'(duty_o), 256);
        wait_periods(2);

        // Fault mid-period, ignored clear, then proper clear.
        wait_cnt(50);
        fault = 1'b1;
        @(negedge clk);
        chk("flt_flag", int'(fault_flag), 1);
        chk("flt_gates", int'({hi_a, lo_a, hi_b, lo_b}), 0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        chk("flt_clr_ignored", int'(fault_flag), 1);
        strobe(16'h0400);
        fault = 1'b0;
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("flt_cleared", int'(fault_flag), 0);
        wait_periods(2);
        chk("flt_resume_duty", int'(duty_o), 64);
        chk("flt_resume_dir", int'(dir_o), 0);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            u_valid = 1'b0; fault_clr = 1'b0; enable = 1'b1;
            if ($urandom_range(0, 399) == 0 || (m_cnt == P - 1 && $urandom_range(0, 1) == 0)) begin
                case ($urandom_range(0, 4))
                    0: rv = 16'h8000;
                    1: rv = 16'h7FFF;
                    2: rv = 16'($urandom_range(0, 255)) - 16'd128;
                    default: rv = 16'($urandom);
                endcase
                u = rv; u_valid = 1'b1;
            end
            if ($urandom_range(0, 2999) == 0) enable = 1'b0;
            if (!fault && $urandom_range(0, 2999) == 0) fault = 1'b1;
            else if (fault && $urandom_range(0, 49) == 0) fault = 1'b0;
            if ($urandom_range(0, 99) == 0) fault_clr = 1'b1;
        end

        // Back to RUN, then reset mid-period.
        @(negedge clk);
        u_valid = 1'b0; enable = 1'b1; fault = 1'b0; fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        strobe(16'h0800);
        wait_periods(2);
        wait_cnt(700);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_gates", int'({hi_a, lo_a, hi_b, lo_b}), 0);
        chk("mid_rst_duty", int'(duty_o), 0);
        chk("mid_rst_flags", int'({period_st, dir_o, sat, fault_flag}), 0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
